// File: rtl/gerenciar_display_seq_if.sv
// gerenciar_display_seq_if: controller/sensor inputs and 7-segment outputs of the display sequencer.
// Revision 1.0
`default_nettype none

interface gerenciar_display_seq_if #(
  parameter int W_ANDAR = 2
);
  logic [W_ANDAR-1:0] andar;
  logic               S;
  logic               D;
  logic               P;
  logic               A;
  logic               B;
  logic               modo;
  logic [1:0]         sel_manual;
  logic [6:0]         seg;
  logic [1:0]         pagina;

  modport master (
    output andar, S, D, P, A, B, modo, sel_manual,
    input  seg, pagina
  );

  modport slave (
    input  andar, S, D, P, A, B, modo, sel_manual,
    output seg, pagina
  );
endinterface

`default_nettype wire

// File: rtl/gerenciar_display_seq.sv
// gerenciar_display_seq: rotating/manual page sequencer for one active-low 7-segment digit.
// Revision 1.0
`default_nettype none

module gerenciar_display_seq #(
  parameter int N_ANDARES = 4,
  parameter int W_ANDAR   = 2,
  parameter int DWELL     = 50000000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gerenciar_display_seq_if.slave  bus
);

  localparam int c_DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int c_BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(DWELL - 1);
  localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_DIV - 1);

  localparam logic [6:0] c_GLYPH_E     = 7'b0110000;
  localparam logic [6:0] c_GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] c_GLYPH_UP    = 7'b0011101;
  localparam logic [6:0] c_GLYPH_DOWN  = 7'b1100011;
  localparam logic [6:0] c_GLYPH_STOP  = 7'b0110110;

  typedef enum logic [1:0] {
    PG_FLOOR = 2'd0,
    PG_MOVE  = 2'd1,
    PG_BLANK = 2'd2,
    PG_OCC   = 2'd3
  } page_t;

  page_t              r_page;
  page_t              w_page_nxt;
  logic [c_DW-1:0]    r_dwell;
  logic [c_DW-1:0]    w_dwell_nxt;
  logic [c_BW-1:0]    r_blink;
  logic               r_phase;
  logic [W_ANDAR-1:0] r_andar_prev;
  logic [6:0]         r_seg;
  logic [1:0]         r_pagina;
  logic [6:0]         w_seg;
  logic               w_floor_evt;
  logic               w_moving;

  function automatic logic [6:0] f_digit(input logic [3:0] v);
    case (v)
      4'd0:    f_digit = 7'b0000001;
      4'd1:    f_digit = 7'b1001111;
      4'd2:    f_digit = 7'b0010010;
      4'd3:    f_digit = 7'b0000110;
      4'd4:    f_digit = 7'b1001100;
      4'd5:    f_digit = 7'b0100100;
      4'd6:    f_digit = 7'b0100000;
      4'd7:    f_digit = 7'b0001111;
      4'd8:    f_digit = 7'b0000000;
      4'd9:    f_digit = 7'b0000100;
      default: f_digit = c_GLYPH_BLANK;
    endcase
  endfunction

  assign w_floor_evt = (bus.andar != r_andar_prev);
  assign w_moving    = (bus.S ^ bus.D) & ~bus.P;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_page  <= PG_FLOOR;
      r_dwell <= '0;
    end else begin
      r_page  <= w_page_nxt;
      r_dwell <= w_dwell_nxt;
    end
  end

  // Floor event outranks the dwell wrap; page 2 only reachable manually and exits to 3.
  always_comb begin
    w_page_nxt  = r_page;
    w_dwell_nxt = r_dwell;
    if (!bus.modo) begin
      w_page_nxt  = page_t'(bus.sel_manual);
      w_dwell_nxt = '0;
    end else if (w_floor_evt) begin
      w_page_nxt  = PG_FLOOR;
      w_dwell_nxt = '0;
    end else if (r_dwell == c_DWELL_LAST) begin
      w_dwell_nxt = '0;
      case (r_page)
        PG_FLOOR: w_page_nxt = PG_MOVE;
        PG_MOVE:  w_page_nxt = PG_OCC;
        PG_BLANK: w_page_nxt = PG_OCC;
        default:  w_page_nxt = PG_FLOOR;
      endcase
    end else begin
      w_dwell_nxt = r_dwell + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink      <= '0;
      r_phase      <= 1'b0;
      r_andar_prev <= '0;
    end else begin
      r_andar_prev <= bus.andar;
      if (r_blink == c_BLINK_LAST) begin
        r_blink <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_blink <= r_blink + 1'b1;
      end
    end
  end

  always_comb begin
    w_seg = c_GLYPH_BLANK;
    case (r_page)
      PG_FLOOR: begin
        if (int'(bus.andar) < N_ANDARES) w_seg = f_digit(4'(bus.andar));
        else                             w_seg = c_GLYPH_E;
      end
      PG_MOVE: begin
        if (w_moving && r_phase) begin
          w_seg = c_GLYPH_BLANK;
        end else begin
          case ({bus.S, bus.D, bus.P})
            3'b100:  w_seg = c_GLYPH_UP;
            3'b010:  w_seg = c_GLYPH_DOWN;
            3'b001:  w_seg = c_GLYPH_STOP;
            default: w_seg = c_GLYPH_E;
          endcase
        end
      end
      PG_BLANK: w_seg = c_GLYPH_BLANK;
      default:  w_seg = f_digit({3'b000, bus.A} + {3'b000, bus.B});
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg    <= c_GLYPH_BLANK;
      r_pagina <= 2'd0;
    end else begin
      r_seg    <= w_seg;
      r_pagina <= r_page;
    end
  end

  assign bus.seg    = r_seg;
  assign bus.pagina = r_pagina;

endmodule

`default_nettype wire
